// File: rtl/ntt_engine_arbiter.sv
// Round-robin arbiter and job sequencer that time-shares one NTT engine among NUM_REQ clients.
// Latency: req->gnt 1 cycle, go->eng_start 1 cycle, eng_done->cli_done 1 cycle; load/read paths are combinational.
// Backpressure: no grant while eng_busy; an owner keeps the engine until rel or hold timeout (never during RUN).
// Ports: req/rel/go/cli_load/cli_*_addr/cli_load_data per client (flattened, client i at slice i);
//        gnt/cli_done/owner/timeout/jobs_done status; eng_* drive and observe the shared engine.
module ntt_engine_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int N          = 256,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int HOLD_MAX   = 1024
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [NUM_REQ-1:0]                             req,
    input  logic [NUM_REQ-1:0]                             rel,
    input  logic [NUM_REQ-1:0]                             go,
    input  logic [NUM_REQ-1:0]                             cli_load,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]                  cli_load_addr,
    input  logic [NUM_REQ*WIDTH-1:0]                       cli_load_data,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]                  cli_read_addr,
    output logic [NUM_REQ-1:0]                             gnt,
    output logic [NUM_REQ-1:0]                             cli_done,
    output logic [WIDTH-1:0]                               cli_read_data,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] owner,
    output logic                                           timeout,
    output logic [15:0]                                    jobs_done,
    output logic                                           eng_start,
    output logic                                           eng_load_coeff,
    output logic [ADDR_WIDTH-1:0]                          eng_load_addr,
    output logic [ADDR_WIDTH-1:0]                          eng_read_addr,
    output logic [WIDTH-1:0]                               eng_load_data,
    input  logic                                           eng_done,
    input  logic                                           eng_busy,
    input  logic [WIDTH-1:0]                               eng_read_data
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (HOLD_MAX > 0) ? HW'(HOLD_MAX - 1) : '0;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;

    logic [2:0]         state_q,     state_d;
    logic [NUM_REQ-1:0] gnt_q,       gnt_d;
    logic [NUM_REQ-1:0] cli_done_q,  cli_done_d;
    logic [OW-1:0]      owner_q,     owner_d;
    logic [OW-1:0]      rr_ptr_q,    rr_ptr_d;
    logic               timeout_q,   timeout_d;
    logic [15:0]        jobs_done_q, jobs_done_d;
    logic [HW-1:0]      hold_q,      hold_d;

    logic                  own_load, own_rel, own_go, hold_expire;
    logic [ADDR_WIDTH-1:0] own_load_addr, own_read_addr;
    logic [WIDTH-1:0]      own_load_data;
    logic [OW-1:0]         nxt_ptr, pick_idx, cand;
    logic                  pick_vld;

    // Owner-selected client signals; everything from non-owners is ignored.
    always_comb begin
        own_load      = cli_load[owner_q];
        own_rel       = rel[owner_q];
        own_go        = go[owner_q];
        own_load_addr = ADDR_WIDTH'(cli_load_addr >> (owner_q * ADDR_WIDTH));
        own_read_addr = ADDR_WIDTH'(cli_read_addr >> (owner_q * ADDR_WIDTH));
        own_load_data = WIDTH'(cli_load_data >> (owner_q * WIDTH));
        nxt_ptr       = OW'((int'(owner_q) + 1) % NUM_REQ);
        hold_expire   = (HOLD_MAX != 0) && (hold_q == HOLD_LAST);
    end

    // First requester at or after rr_ptr: scan from the far end so the nearest hit wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = OW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        cli_done_d  = '0;
        timeout_d   = 1'b0;
        jobs_done_d = jobs_done_q;
        hold_d      = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_vld && !eng_busy) begin
                    owner_d = pick_idx;
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                // Any owner load counts as activity and restarts the hold window.
                hold_d = own_load ? '0 : hold_q + 1'b1;
                if (own_rel) begin
                    state_d  = S_IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = nxt_ptr;
                end else if (own_go) begin
                    state_d = S_START;
                end else if (!own_load && hold_expire) begin
                    state_d   = S_IDLE;
                    gnt_d     = '0;
                    rr_ptr_d  = nxt_ptr;
                    timeout_d = 1'b1;
                end
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                // The engine is never abandoned mid-transform: rel and the hold timer are ignored here.
                if (eng_done) begin
                    state_d     = S_READ;
                    cli_done_d  = gnt_q;
                    jobs_done_d = jobs_done_q + 16'd1;
                end
            end
            S_READ: begin
                hold_d = hold_q + 1'b1;
                if (own_rel) begin
                    state_d  = S_IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = nxt_ptr;
                end else if (hold_expire) begin
                    state_d   = S_IDLE;
                    gnt_d     = '0;
                    rr_ptr_d  = nxt_ptr;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            cli_done_q  <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            timeout_q   <= 1'b0;
            jobs_done_q <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            cli_done_q  <= cli_done_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            timeout_q   <= timeout_d;
            jobs_done_q <= jobs_done_d;
            hold_q      <= hold_d;
        end
    end

    assign gnt            = gnt_q;
    assign cli_done       = cli_done_q;
    assign owner          = owner_q;
    assign timeout        = timeout_q;
    assign jobs_done      = jobs_done_q;
    assign eng_start      = (state_q == S_START);
    assign eng_load_coeff = (state_q == S_GRANT) && own_load;
    assign eng_load_addr  = (state_q == S_GRANT) ? own_load_addr : '0;
    assign eng_load_data  = (state_q == S_GRANT) ? own_load_data : '0;
    assign eng_read_addr  = (state_q == S_READ)  ? own_read_addr : '0;
    assign cli_read_data  = eng_read_data;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_load_in_range: assert property (@(posedge clk) disable iff (rst)
        eng_load_coeff |-> (int'(eng_load_addr) < N));

endmodule

// File: tb/tb_ntt_engine_arbiter.sv
module tb_ntt_engine_arbiter;

    localparam int NR = 2;
    localparam int W  = 32;
    localparam int AW = 8;
    localparam int HM = 16;

    logic              clk, rst;
    logic [NR-1:0]     req, rel, go, cli_load;
    logic [NR*AW-1:0]  cli_load_addr, cli_read_addr;
    logic [NR*W-1:0]   cli_load_data;
    logic [NR-1:0]     gnt, cli_done;
    logic [W-1:0]      cli_read_data;
    logic [0:0]        owner;
    logic              timeout;
    logic [15:0]       jobs_done;
    logic              eng_start, eng_load_coeff;
    logic [AW-1:0]     eng_load_addr, eng_read_addr;
    logic [W-1:0]      eng_load_data;
    logic              eng_done, eng_busy;
    logic [W-1:0]      eng_read_data;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;   // client that has top priority next
    int model_jobs = 0;  // transforms completed since reset

    ntt_engine_arbiter #(.NUM_REQ(NR), .N(256), .WIDTH(W), .ADDR_WIDTH(AW), .HOLD_MAX(HM)) dut (
        .clk(clk), .rst(rst), .req(req), .rel(rel), .go(go), .cli_load(cli_load),
        .cli_load_addr(cli_load_addr), .cli_load_data(cli_load_data), .cli_read_addr(cli_read_addr),
        .gnt(gnt), .cli_done(cli_done), .cli_read_data(cli_read_data), .owner(owner),
        .timeout(timeout), .jobs_done(jobs_done), .eng_start(eng_start),
        .eng_load_coeff(eng_load_coeff), .eng_load_addr(eng_load_addr), .eng_read_addr(eng_read_addr),
        .eng_load_data(eng_load_data), .eng_done(eng_done), .eng_busy(eng_busy),
        .eng_read_data(eng_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [NR-1:0] oh(input int c);
        return NR'(1) << c;
    endfunction

    // Round-robin rule: first requesting client at or after the priority pointer, cyclically.
    function automatic int rr_pick(input int ptr, input logic [NR-1:0] r);
        for (int i = 0; i < NR; i++) begin
            if ((r & oh((ptr + i) % NR)) != '0) return (ptr + i) % NR;
        end
        return 0;
    endfunction

    function automatic logic [NR*AW-1:0] put_a(input logic [NR*AW-1:0] v, input int c, input logic [AW-1:0] a);
        logic [NR*AW-1:0] m;
        m = {{(NR-1)*AW{1'b0}}, {AW{1'b1}}} << (c * AW);
        return (v & ~m) | ({{(NR-1)*AW{1'b0}}, a} << (c * AW));
    endfunction

    function automatic logic [NR*W-1:0] put_d(input logic [NR*W-1:0] v, input int c, input logic [W-1:0] d);
        logic [NR*W-1:0] m;
        m = {{(NR-1)*W{1'b0}}, {W{1'b1}}} << (c * W);
        return (v & ~m) | ({{(NR-1)*W{1'b0}}, d} << (c * W));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in the first GRANT cycle of client c; leaves in the IDLE cycle after its release.
    task automatic do_job(input int c, input int nloads, input bit seq, input bit rel_in_run);
        logic [AW-1:0] a, ra;
        logic [W-1:0]  d, rd;
        int            w;
        for (int k = 0; k < nloads; k++) begin
            a = seq ? AW'(k) : AW'($urandom);
            d = seq ? W'(k) : $urandom;
            cli_load      = oh(c) | (~oh(c) & NR'($urandom));
            cli_load_addr = put_a((NR*AW)'($urandom), c, a);
            cli_load_data = put_d({$urandom, $urandom}, c, d);
            #1;
            checks++;
            if ({eng_load_coeff, eng_load_addr, eng_load_data} !== {1'b1, a, d}) begin
                errors++;
                $display("FAIL job_load c=%0d k=%0d: got coeff=%b addr=%h data=%h, required 1 %h %h",
                         c, k, eng_load_coeff, eng_load_addr, eng_load_data, a, d);
            end
            tick();
        end
        cli_load = '0;
        go = oh(c) | (~oh(c) & NR'($urandom));
        tick();
        go = '0;
        checks++;
        if ({eng_start, gnt} !== {1'b1, oh(c)}) begin
            errors++;
            $display("FAIL job_start c=%0d: got start=%b gnt=%b, required 1 %b", c, eng_start, gnt, oh(c));
        end
        tick();
        checks++;
        if (eng_start !== 1'b0) begin
            errors++;
            $display("FAIL job_start_pulse c=%0d: got %b, required 0", c, eng_start);
        end
        w = $urandom_range(0, 5);
        for (int k = 0; k < w; k++) begin
            rel = rel_in_run ? oh(c) : '0;
            tick();
            checks++;
            if ({gnt, cli_done} !== {oh(c), {NR{1'b0}}}) begin
                errors++;
                $display("FAIL job_run_hold c=%0d: got gnt=%b done=%b, required %b 00", c, gnt, cli_done, oh(c));
            end
        end
        rel = '0;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        model_jobs++;
        checks++;
        if ({cli_done, jobs_done} !== {oh(c), 16'(model_jobs)}) begin
            errors++;
            $display("FAIL job_done c=%0d: got done=%b jobs=%0d, required %b %0d", c, cli_done, jobs_done, oh(c), model_jobs);
        end
        ra = AW'($urandom);
        rd = $urandom;
        cli_read_addr = put_a((NR*AW)'($urandom), c, ra);
        eng_read_data = rd;
        #1;
        checks++;
        if ({eng_read_addr, cli_read_data, eng_load_coeff} !== {ra, rd, 1'b0}) begin
            errors++;
            $display("FAIL job_read c=%0d: got raddr=%h rdata=%h load=%b, required %h %h 0",
                     c, eng_read_addr, cli_read_data, eng_load_coeff, ra, rd);
        end
        tick();
        checks++;
        if ({cli_done, gnt} !== {{NR{1'b0}}, oh(c)}) begin
            errors++;
            $display("FAIL job_done_pulse c=%0d: got done=%b gnt=%b, required 00 %b", c, cli_done, gnt, oh(c));
        end
        rel = oh(c);
        tick();
        rel = '0;
        model_ptr = (c + 1) % NR;
        checks++;
        if ({gnt, eng_read_addr} !== {{NR{1'b0}}, {AW{1'b0}}}) begin
            errors++;
            $display("FAIL job_release c=%0d: got gnt=%b raddr=%h, required 00 00", c, gnt, eng_read_addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0; rel = '0; go = '0; cli_load = '0;
        cli_load_addr = '0; cli_load_data = '0; cli_read_addr = '0;
        eng_done = 1'b0; eng_busy = 1'b0; eng_read_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if ({gnt, cli_done, timeout, eng_start, eng_load_coeff} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got gnt=%b done=%b to=%b start=%b load=%b, required all 0",
                     gnt, cli_done, timeout, eng_start, eng_load_coeff);
        end
        checks++;
        if ({owner, jobs_done, eng_read_addr, eng_load_addr} !== '0) begin
            errors++;
            $display("FAIL reset_state: got owner=%0d jobs=%0d raddr=%h laddr=%h, required 0",
                     owner, jobs_done, eng_read_addr, eng_load_addr);
        end
        tick();
        checks++;
        if (gnt !== '0) begin
            errors++;
            $display("FAIL reset_idle: got gnt=%b, required 00", gnt);
        end
    endtask

    task automatic test_single_job();
        int exp;
        req = oh(0);
        exp = rr_pick(model_ptr, req);
        tick();
        req = '0;  // dropping req must not release the grant
        checks++;
        if ({gnt, int'(owner) == exp} !== {oh(exp), 1'b1}) begin
            errors++;
            $display("FAIL single_grant: got gnt=%b owner=%0d, required %b %0d", gnt, owner, oh(exp), exp);
        end
        checks++;
        if (eng_read_addr !== '0) begin
            errors++;
            $display("FAIL single_raddr_grant: got %h, required 00", eng_read_addr);
        end
        do_job(exp, 256, 1'b1, 1'b0);
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] r;
        int exp;
        for (int it = 0; it < 6; it++) begin
            r = (it < 3) ? {NR{1'b1}} : NR'($urandom_range(1, (1 << NR) - 1));
            req = r;
            exp = rr_pick(model_ptr, r);
            tick();
            checks++;
            if ({gnt, int'(owner) == exp} !== {oh(exp), 1'b1}) begin
                errors++;
                $display("FAIL rr_grant it=%0d req=%b: got gnt=%b owner=%0d, required %b %0d",
                         it, r, gnt, owner, oh(exp), exp);
            end
            do_job(exp, $urandom_range(1, 6), 1'b0, it[0]);
        end
        req = '0;
        tick();
    endtask

    task automatic test_isolation_abort();
        int c;
        logic [AW-1:0] oa;
        logic [W-1:0]  od;
        c = $urandom_range(0, NR - 1);
        req = oh(c);
        tick();
        req = '0;
        checks++;
        if (gnt !== oh(rr_pick(model_ptr, oh(c)))) begin
            errors++;
            $display("FAIL iso_grant: got gnt=%b, required %b", gnt, oh(c));
        end
        for (int k = 0; k < 4; k++) begin
            oa = AW'($urandom);
            od = $urandom;
            cli_load      = (k % 2 == 0) ? ~oh(c) : '0;
            cli_load_addr = put_a((NR*AW)'($urandom), c, oa);
            cli_load_data = put_d({$urandom, $urandom}, c, od);
            #1;
            checks++;
            if ({eng_load_coeff, eng_load_addr, eng_load_data} !== {1'b0, oa, od}) begin
                errors++;
                $display("FAIL iso_foreign_load k=%0d: got coeff=%b addr=%h data=%h, required 0 %h %h",
                         k, eng_load_coeff, eng_load_addr, eng_load_data, oa, od);
            end
            tick();
        end
        cli_load = '0;
        go  = oh(c);
        rel = oh(c);
        tick();
        go  = '0;
        rel = '0;
        model_ptr = (c + 1) % NR;
        checks++;
        if ({gnt, eng_start} !== {{NR{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL abort_release: got gnt=%b start=%b, required 00 0", gnt, eng_start);
        end
        tick();
        checks++;
        if ({eng_start, jobs_done} !== {1'b0, 16'(model_jobs)}) begin
            errors++;
            $display("FAIL abort_nostart: got start=%b jobs=%0d, required 0 %0d", eng_start, jobs_done, model_jobs);
        end
    endtask

    task automatic test_timeout();
        int a, b, c, pre;
        req = {NR{1'b1}};
        a = rr_pick(model_ptr, req);
        tick();
        pre = $urandom_range(1, 10);
        for (int k = 0; k < pre; k++) begin
            checks++;
            if ({gnt, timeout} !== {oh(a), 1'b0}) begin
                errors++;
                $display("FAIL to_pre k=%0d: got gnt=%b to=%b, required %b 0", k, gnt, timeout, oh(a));
            end
            tick();
        end
        cli_load = oh(a);
        tick();
        cli_load = '0;
        // A load restarts the window: HM more full cycles of grant, then the revoke.
        for (int k = 0; k < HM; k++) begin
            checks++;
            if ({gnt, timeout} !== {oh(a), 1'b0}) begin
                errors++;
                $display("FAIL to_grant_hold k=%0d: got gnt=%b to=%b, required %b 0", k, gnt, timeout, oh(a));
            end
            tick();
        end
        model_ptr = (a + 1) % NR;
        checks++;
        if ({gnt, timeout} !== {{NR{1'b0}}, 1'b1}) begin
            errors++;
            $display("FAIL to_grant_fire: got gnt=%b to=%b, required 00 1", gnt, timeout);
        end
        b = rr_pick(model_ptr, req);
        tick();
        req = oh(b);
        checks++;
        if ({gnt, timeout} !== {oh(b), 1'b0}) begin
            errors++;
            $display("FAIL to_next_grant: got gnt=%b to=%b, required %b 0", gnt, timeout, oh(b));
        end
        go = oh(b);
        tick();
        go = '0;
        tick();
        rel = oh(b);  // held through RUN; honoured only once READ is reached
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (gnt !== oh(b)) begin
                errors++;
                $display("FAIL to_rel_in_run k=%0d: got gnt=%b, required %b", k, gnt, oh(b));
            end
        end
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        model_jobs++;
        checks++;
        if ({gnt, cli_done, jobs_done} !== {oh(b), oh(b), 16'(model_jobs)}) begin
            errors++;
            $display("FAIL to_run_done: got gnt=%b done=%b jobs=%0d, required %b %b %0d",
                     gnt, cli_done, jobs_done, oh(b), oh(b), model_jobs);
        end
        req = '0;
        tick();
        rel = '0;
        model_ptr = (b + 1) % NR;
        checks++;
        if (gnt !== '0) begin
            errors++;
            $display("FAIL to_rel_after_run: got gnt=%b, required 00", gnt);
        end
        c = $urandom_range(0, NR - 1);
        req = oh(c);
        tick();
        req = '0;
        go = oh(c);
        tick();
        go = '0;
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        model_jobs++;
        for (int k = 0; k < HM; k++) begin
            checks++;
            if ({gnt, timeout} !== {oh(c), 1'b0}) begin
                errors++;
                $display("FAIL to_read_hold k=%0d: got gnt=%b to=%b, required %b 0", k, gnt, timeout, oh(c));
            end
            tick();
        end
        model_ptr = (c + 1) % NR;
        checks++;
        if ({gnt, timeout, jobs_done} !== {{NR{1'b0}}, 1'b1, 16'(model_jobs)}) begin
            errors++;
            $display("FAIL to_read_fire: got gnt=%b to=%b jobs=%0d, required 00 1 %0d", gnt, timeout, jobs_done, model_jobs);
        end
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse_width: got %b, required 0", timeout);
        end
    endtask

    task automatic test_busy();
        int c, n;
        c = $urandom_range(0, NR - 1);
        eng_busy = 1'b1;
        req = oh(c);
        n = $urandom_range(2, 6);
        for (int k = 0; k < n; k++) begin
            tick();
            checks++;
            if (gnt !== '0) begin
                errors++;
                $display("FAIL busy_block k=%0d: got gnt=%b, required 00", k, gnt);
            end
        end
        eng_busy = 1'b0;
        tick();
        req = '0;
        checks++;
        if (gnt !== oh(rr_pick(model_ptr, oh(c)))) begin
            errors++;
            $display("FAIL busy_release_grant: got gnt=%b, required %b", gnt, oh(c));
        end
        rel = oh(c);
        tick();
        rel = '0;
        model_ptr = (c + 1) % NR;
    endtask

    task automatic test_reset_mid_run();
        int c;
        c = $urandom_range(0, NR - 1);
        req = oh(c);
        tick();
        req = '0;
        go = oh(c);
        tick();
        go = '0;
        tick();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({gnt, cli_done, timeout, eng_start, eng_load_coeff, owner, jobs_done} !== '0) begin
                errors++;
                $display("FAIL rst_run k=%0d: got gnt=%b done=%b to=%b start=%b load=%b owner=%0d jobs=%0d, required all 0",
                         k, gnt, cli_done, timeout, eng_start, eng_load_coeff, owner, jobs_done);
            end
        end
        rst = 1'b0;
        model_jobs = 0;
        model_ptr = 0;
        req = {NR{1'b1}};
        tick();
        req = '0;
        checks++;
        if ({gnt, owner} !== {oh(rr_pick(model_ptr, {NR{1'b1}})), 1'b0}) begin
            errors++;
            $display("FAIL rst_ptr_cleared: got gnt=%b owner=%0d, required %b 0", gnt, owner, oh(0));
        end
        rel = gnt;
        tick();
        rel = '0;
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_round_robin();
        test_isolation_abort();
        test_timeout();
        test_busy();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt_engine_arbiter.md
# ntt_engine_arbiter

Round-robin arbiter and job sequencer that shares one NTT engine among NUM_REQ requesters. The engine can be the forward or inverse NTT core; it has the start/done/busy/load/read port set. A granted client owns the engine for one whole job: it loads coefficients, the block launches the transform, and the client reads back results. The block sits between the engine and client controllers such as polynomial-multiply sequencers, so the engine does not have to be instantiated once per client.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- N, 256, coefficients per job (used only for documentation/assertions)
- WIDTH, 32, coefficient width
- ADDR_WIDTH, 8, coefficient address width
- HOLD_MAX, 1024, idle-cycle limit in GRANT/READ before forced revoke; 0 disables
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-client job request (level)
- rel  in  NUM_REQ  per-client release (sampled only from owner)
- go  in  NUM_REQ  per-client launch (sampled only from owner in GRANT)
- cli_load  in  NUM_REQ  per-client coefficient write strobe
- cli_load_addr  in  NUM_REQ*ADDR_WIDTH  flattened, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- cli_load_data  in  NUM_REQ*WIDTH  flattened
- cli_read_addr  in  NUM_REQ*ADDR_WIDTH  flattened
- gnt  out  NUM_REQ  one-hot grant, registered
- cli_done  out  NUM_REQ  one-cycle pulse to owner when transform completes
- cli_read_data  out  WIDTH  engine read data, broadcast
- owner  out  $clog2(NUM_REQ) (min 1)  index of current/last owner
- timeout  out  1  one-cycle pulse on forced revoke
- jobs_done  out  16  completed-transform counter, wraps
- eng_start, eng_load_coeff  out  1  engine controls
- eng_load_addr, eng_read_addr  out  ADDR_WIDTH
- eng_load_data  out  WIDTH
- eng_done, eng_busy  in  1  engine status
- eng_read_data  in  WIDTH

## Operation
- States: IDLE, GRANT, START, RUN, READ.
- IDLE:
  - If any req is high and eng_busy is low, pick the first requester at or after rr_ptr, cyclically.
  - Register owner, set gnt[owner], go to GRANT.
  - If eng_busy is high, no grant is issued.
- GRANT:
  - eng_load_coeff/addr/data = owner's cli_load/addr/data, combinational.
  - Non-owner loads are ignored.
  - Owner rel goes to IDLE. rel beats go if both are high in the same cycle.
  - Owner go (without rel) goes to START.
- START: eng_start=1 for exactly this cycle; next state is RUN.
- RUN:
  - Wait for eng_done high, then go to READ.
  - rel and timeout are ignored; the engine is never abandoned mid-transform.
- READ:
  - cli_done[owner] pulses on the first cycle only.
  - eng_read_addr = owner's cli_read_addr.
  - Owner rel goes to IDLE.
- Leaving READ or GRANT to IDLE: gnt clears, and rr_ptr = (owner+1) mod NUM_REQ.
- jobs_done increments on RUN→READ, 16-bit wrap.
- Hold timer:
  - Counts cycles in GRANT and READ.
  - Clears on entry to either state and on each owner cli_load in GRANT.
  - When it reaches HOLD_MAX (nonzero), force IDLE, pulse timeout, and advance rr_ptr.
- Outside GRANT: eng_load_coeff=0 and eng_load_addr/data=0.
- Outside READ: eng_read_addr=0.
- req deassertion by the owner does not release the grant; only rel or timeout does.

## Timing
- Reset values: state IDLE; gnt=0; cli_done=0; timeout=0; eng_start=0; eng_load_coeff=0; owner=0; rr_ptr=0; jobs_done=0; hold timer=0.
- rst asserted in any state, including RUN, returns to IDLE next edge. Engine reset is handled by its own reset.
- req sampled in IDLE at edge t: gnt high from t+1.
- Owner loads are accepted on the same cycle they are presented while gnt is high.
- go sampled at t: eng_start high during t+1 only; RUN from t+2.
- eng_done seen at t in RUN: READ from t+1; cli_done[owner]=1 during t+1 only.
- cli_read_data follows eng_read_data with the engine's own read latency, no added register.
- rel sampled at t: gnt low from t+1; next grant earliest at t+2.
- Back-to-back requesters are served fairly: after owner k releases, k is lowest priority.

## Test plan
- Reset: hold rst 3 cycles mid-RUN → all outputs at reset values next cycle; state IDLE; jobs_done=0.
- Single job: req[0] → gnt=01 one cycle later; load 256 coefficients (addr i, data i) → eng_load mirrors each; go → one-cycle eng_start; eng_done → cli_done[0] pulse, jobs_done=1; read addr 5 → eng_read_addr=5; rel → gnt=00.
- Round-robin: req=11 held continuously, each client releases after its job → grants alternate 01, 10, 01; each gap is ≥1 IDLE cycle.
- Isolation and abort: with client 0 granted, toggle cli_load[1] → eng_load_coeff stays 0; then client 0 asserts go and rel together → IDLE, no eng_start, jobs_done unchanged.
- Timeout: HOLD_MAX=16, owner idles in GRANT → timeout pulses at 16th cycle, gnt clears, next pending client is granted; rel during RUN → ignored until eng_done.
- Busy block: eng_busy=1 with req=01 → no grant while busy; grant one cycle after eng_busy falls.
